// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory sequencer: one outstanding request, RISC-V byte-lane
// alignment for stores, sign/zero extension for loads, fixed response latency.
module lsu_mem_ctrl #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_func3,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [7:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_ren,
  input  logic [XLEN-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | ready to accept a request
  // ACCESS | single-cycle memory strobe, load data captured at its end
  // WAIT   | counting down LATENCY extra cycles
  // RESP   | response held until resp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t          state, state_nx;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            wen_q, err_q;
  logic [2:0]      func3_q;
  logic [3:0]      cnt_q;

  logic            accept, illegal;
  logic [1:0]      lane;
  logic [XLEN-1:0] shifted, load_data;
  logic [3:0]      lane_mask;

  assign accept = (state == IDLE) && req_valid;
  assign lane   = addr_q[1:0];

  always_comb begin
    illegal = 1'b0;
    if (!req_wen && (req_func3 == 3'b011 || req_func3 == 3'b110 || req_func3 == 3'b111))
      illegal = 1'b1;
    if (req_wen && req_func3 >= 3'b011)
      illegal = 1'b1;
    if (req_func3[1:0] == 2'b01 && req_addr[0])
      illegal = 1'b1;
    if (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      illegal = 1'b1;
  end

  assign shifted = mem_rdata >> {lane, 3'b000};

  always_comb begin
    load_data = '0;
    case (func3_q)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    case (func3_q[1:0])
      2'b00:   lane_mask = 4'b0001 << lane;
      2'b01:   lane_mask = 4'b0011 << lane;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = illegal ? RESP : ACCESS;
      ACCESS:  state_nx = (LAT == 4'd0) ? RESP : WAIT;
      WAIT:    if (cnt_q <= 4'd1) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      func3_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
        func3_q <= req_func3;
        err_q   <= illegal;
        rdata_q <= '0;
      end
      if (state == ACCESS) begin
        if (!wen_q) rdata_q <= load_data;
        cnt_q <= LAT;
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Memory bus is quiet (all zero) everywhere except the ACCESS cycle.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_wmask = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_ren  = !wen_q;
      mem_wen  = wen_q;
      mem_addr = {addr_q[XLEN-1:2], 2'b00};
      if (wen_q) begin
        mem_wmask = {4'b0000, lane_mask};
        mem_wdata = wdata_q << {lane, 3'b000};
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, hand-written corner sequences and
// random traffic against a byte-addressed reference memory model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        sel4;
  logic        req_valid, req_wen, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        tbl_mode;
  logic [31:0] tbl_rdata, mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_wen, a_mem_ren;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [7:0]  a_mem_wmask;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_wen, b_mem_ren;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [7:0]  b_mem_wmask;

  logic        req_ready, resp_valid, resp_err, mem_wen, mem_ren;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;

  logic [31:0] mem_word [16];
  logic [7:0]  ref_mem  [64];

  lsu_mem_ctrl #(.XLEN(32), .LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid && !sel4), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel4),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_addr(a_mem_addr), .mem_wen(a_mem_wen), .mem_wmask(a_mem_wmask),
    .mem_wdata(a_mem_wdata), .mem_ren(a_mem_ren), .mem_rdata(mem_rdata)
  );

  lsu_mem_ctrl #(.XLEN(32), .LATENCY(4)) dut_l4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid && sel4), .req_ready(b_req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready && sel4),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_addr(b_mem_addr), .mem_wen(b_mem_wen), .mem_wmask(b_mem_wmask),
    .mem_wdata(b_mem_wdata), .mem_ren(b_mem_ren), .mem_rdata(mem_rdata)
  );

  assign req_ready  = sel4 ? b_req_ready  : a_req_ready;
  assign resp_valid = sel4 ? b_resp_valid : a_resp_valid;
  assign resp_rdata = sel4 ? b_resp_rdata : a_resp_rdata;
  assign resp_err   = sel4 ? b_resp_err   : a_resp_err;
  assign mem_addr   = sel4 ? b_mem_addr   : a_mem_addr;
  assign mem_wen    = sel4 ? b_mem_wen    : a_mem_wen;
  assign mem_ren    = sel4 ? b_mem_ren    : a_mem_ren;
  assign mem_wmask  = sel4 ? b_mem_wmask  : a_mem_wmask;
  assign mem_wdata  = sel4 ? b_mem_wdata  : a_mem_wdata;
  assign mem_rdata  = tbl_mode ? tbl_rdata : mem_word[mem_addr[5:2]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drives one request, keeps noise on req_* while busy, and records what the
  // memory bus and response side did. Cycle 1 is the cycle after acceptance.
  task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                         input logic [2:0] f3, input int hold,
                         output int n_strobe, output int strobe_at,
                         output logic [31:0] s_addr, output logic [31:0] s_wdata,
                         output logic [7:0] s_mask, output logic s_ren, output logic s_wen,
                         output int resp_at, output logic [31:0] rdata, output logic err,
                         output logic stable, output logic busy_ok);
    int waited;
    n_strobe = 0; strobe_at = -1; s_addr = '0; s_wdata = '0; s_mask = '0;
    s_ren = 1'b0; s_wen = 1'b0; resp_at = -1; rdata = '0; err = 1'b0;
    stable = 1'b1; busy_ok = 1'b1; waited = 0;
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wdata; req_func3 = f3;
    @(posedge clock); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (req_ready) busy_ok = 1'b0;
      if (mem_ren || mem_wen) begin
        n_strobe++; strobe_at = cyc; s_addr = mem_addr; s_wdata = mem_wdata;
        s_mask = mem_wmask; s_ren = mem_ren; s_wen = mem_wen;
        if (mem_wen)
          for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem_word[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (resp_valid) begin
        if (resp_at < 0) begin
          resp_at = cyc; rdata = resp_rdata; err = resp_err;
        end else if (resp_rdata !== rdata || resp_err !== err) begin
          stable = 1'b0;
        end
        if (waited >= hold) begin
          resp_ready = 1'b1; req_valid = 1'b0;
          @(posedge clock); #1;
          resp_ready = 1'b0;
          break;
        end
        waited++;
      end
      req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
      req_wen = 1'($urandom_range(0, 1)); req_wdata = $urandom; req_func3 = 3'($urandom);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
  endtask

  // Reference: byte-addressed little-endian memory and the RISC-V access rules.
  function automatic void model(input logic [31:0] addr, input logic wen, input logic [2:0] f3,
                                input logic [31:0] wdata, output logic err, output logic [31:0] rd);
    int     nbytes = 1 << f3[1:0];
    int     off    = int'(addr[5:0]);
    bit     legal;
    longint v;
    legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (legal && (off % nbytes) != 0) legal = 1'b0;
    err = !legal;
    rd  = '0;
    if (legal && wen)
      for (int k = 0; k < nbytes; k++) ref_mem[off + k] = wdata[8*k +: 8];
    if (legal && !wen) begin
      v = 0;
      for (int k = 0; k < nbytes; k++) v += longint'(ref_mem[off + k]) << (8*k);
      if (!f3[2] && nbytes < 4 && v >= (longint'(1) << (8*nbytes - 1)))
        v -= longint'(1) << (8*nbytes);
      rd = v[31:0];
    end
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] mrd;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_maddr;
    logic [7:0]  e_mask;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tv [12];

  int          n_strobe, strobe_at, resp_at;
  logic [31:0] s_addr, s_wdata, rdata;
  logic [7:0]  s_mask;
  logic        s_ren, s_wen, err, stable, busy_ok;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e_err, wen;
    logic [31:0] e_rd, addr, wdata;
    logic [2:0]  f3;
    int          r, lat;

    tv[0]  = '{32'h80000004, 1'b0, 32'h0,        3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h80000004, 8'h00, 32'h0};
    tv[1]  = '{32'h80000003, 1'b0, 32'h0,        3'd0, 32'h80FF7F01, 32'hFFFFFF80, 1'b0, 32'h80000000, 8'h00, 32'h0};
    tv[2]  = '{32'h80000003, 1'b0, 32'h0,        3'd4, 32'h80FF7F01, 32'h00000080, 1'b0, 32'h80000000, 8'h00, 32'h0};
    tv[3]  = '{32'h80000002, 1'b0, 32'h0,        3'd5, 32'h80FF7F01, 32'h000080FF, 1'b0, 32'h80000000, 8'h00, 32'h0};
    tv[4]  = '{32'h80000002, 1'b1, 32'h0000ABCD, 3'd1, 32'h11111111, 32'h0,        1'b0, 32'h80000000, 8'h0C, 32'hABCD0000};
    tv[5]  = '{32'h80000006, 1'b1, 32'h12345678, 3'd2, 32'h0,        32'h0,        1'b1, 32'h0,        8'h00, 32'h0};
    tv[6]  = '{32'h80000001, 1'b0, 32'h0,        3'd1, 32'h0,        32'h0,        1'b1, 32'h0,        8'h00, 32'h0};
    tv[7]  = '{32'h80000000, 1'b0, 32'h0,        3'd3, 32'h0,        32'h0,        1'b1, 32'h0,        8'h00, 32'h0};
    tv[8]  = '{32'h80000002, 1'b0, 32'h0,        3'd1, 32'h80FF7F01, 32'hFFFF80FF, 1'b0, 32'h80000000, 8'h00, 32'h0};
    tv[9]  = '{32'h80000003, 1'b1, 32'h12345678, 3'd0, 32'h0,        32'h0,        1'b0, 32'h80000000, 8'h08, 32'h78000000};
    tv[10] = '{32'h80000000, 1'b1, 32'h12345678, 3'd4, 32'h0,        32'h0,        1'b1, 32'h0,        8'h00, 32'h0};
    tv[11] = '{32'h80000001, 1'b0, 32'h0,        3'd0, 32'h12345678, 32'h00000056, 1'b0, 32'h80000000, 8'h00, 32'h0};

    sel4 = 1'b0; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_func3 = '0;
    tbl_mode = 1'b1; tbl_rdata = '0;
    for (int w = 0; w < 16; w++) mem_word[w] = '0;
    for (int b = 0; b < 64; b++) ref_mem[b] = '0;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      sel4 = (d == 1); #1;
      chk($sformatf("rst%0d req_ready", d), {31'b0, req_ready}, 32'd1);
      chk($sformatf("rst%0d resp_valid", d), {31'b0, resp_valid}, 32'd0);
      chk($sformatf("rst%0d resp_rdata", d), resp_rdata, 32'd0);
      chk($sformatf("rst%0d resp_err", d), {31'b0, resp_err}, 32'd0);
      chk($sformatf("rst%0d mem_bus", d),
          mem_addr | mem_wdata | {24'b0, mem_wmask} | {30'b0, mem_wen, mem_ren}, 32'd0);
    end
    sel4 = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) begin
      tbl_rdata = tv[i].mrd;
      chk($sformatf("tv%0d ready", i), {31'b0, req_ready}, 32'd1);
      run_txn(tv[i].addr, tv[i].wen, tv[i].wdata, tv[i].f3, 0, n_strobe, strobe_at,
              s_addr, s_wdata, s_mask, s_ren, s_wen, resp_at, rdata, err, stable, busy_ok);
      chk($sformatf("tv%0d rdata", i), rdata, tv[i].e_rdata);
      chk($sformatf("tv%0d err", i), {31'b0, err}, {31'b0, tv[i].e_err});
      chk($sformatf("tv%0d resp_latency", i), resp_at, tv[i].e_err ? 32'd1 : 32'd3);
      chk($sformatf("tv%0d strobes", i), n_strobe, tv[i].e_err ? 32'd0 : 32'd1);
      chk($sformatf("tv%0d busy_ready", i), {31'b0, busy_ok}, 32'd1);
      if (!tv[i].e_err) begin
        chk($sformatf("tv%0d strobe_cycle", i), strobe_at, 32'd1);
        chk($sformatf("tv%0d mem_addr", i), s_addr, tv[i].e_maddr);
        chk($sformatf("tv%0d mem_ren", i), {31'b0, s_ren}, {31'b0, !tv[i].wen});
        chk($sformatf("tv%0d mem_wen", i), {31'b0, s_wen}, {31'b0, tv[i].wen});
        if (tv[i].wen) begin
          chk($sformatf("tv%0d mem_wmask", i), {24'b0, s_mask}, {24'b0, tv[i].e_mask});
          chk($sformatf("tv%0d mem_wdata", i), s_wdata, tv[i].e_wdata);
        end
      end
    end

    // Response backpressure: five cycles of resp_ready=0 with request noise.
    tbl_rdata = 32'hCAFEF00D;
    run_txn(32'h80000008, 1'b0, 32'h0, 3'd2, 5, n_strobe, strobe_at,
            s_addr, s_wdata, s_mask, s_ren, s_wen, resp_at, rdata, err, stable, busy_ok);
    chk("hold rdata", rdata, 32'hCAFEF00D);
    chk("hold stable", {31'b0, stable}, 32'd1);
    chk("hold busy_ready", {31'b0, busy_ok}, 32'd1);
    chk("hold strobes", n_strobe, 32'd1);
    chk("hold back_idle", {31'b0, req_ready}, 32'd1);
    chk("hold no_resp_after", {31'b0, resp_valid}, 32'd0);
    @(posedge clock); #1;
    chk("hold noise_not_taken", {30'b0, mem_ren, mem_wen}, 32'd0);

    // LATENCY=4 instance: normal latency, then reset in the middle of WAIT.
    sel4 = 1'b1; #1;
    tbl_rdata = 32'h0BADF00D;
    run_txn(32'h8000000C, 1'b0, 32'h0, 3'd2, 0, n_strobe, strobe_at,
            s_addr, s_wdata, s_mask, s_ren, s_wen, resp_at, rdata, err, stable, busy_ok);
    chk("l4 resp_latency", resp_at, 32'd6);
    chk("l4 rdata", rdata, 32'h0BADF00D);

    tbl_rdata = 32'h55AA55AA;
    req_valid = 1'b1; req_addr = 32'h80000010; req_wen = 1'b0; req_func3 = 3'd2;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("l4 in_wait busy", {30'b0, req_ready, resp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("l4 rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("l4 rst resp_rdata", resp_rdata, 32'd0);
    chk("l4 rst resp_err", {31'b0, resp_err}, 32'd0);
    begin
      int n_rv, n_st;
      n_rv = 0; n_st = 0;
      for (int c = 0; c < 12; c++) begin
        if (resp_valid) n_rv++;
        if (mem_ren || mem_wen) n_st++;
        @(posedge clock); #1;
      end
      chk("l4 rst resp_valid_never", n_rv, 32'd0);
      chk("l4 rst no_strobes", n_st, 32'd0);
    end

    // Random traffic on both instances against the reference memory.
    tbl_mode = 1'b0;
    for (int w = 0; w < 16; w++) begin
      mem_word[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_word[w][8*b +: 8];
    end
    for (int i = 0; i < 240; i++) begin
      sel4 = (i % 4 == 3); #1;
      lat = sel4 ? 4 : 1;
      wen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        r  = $urandom_range(0, 4);
        f3 = (r > 2) ? 3'(r + 1) : 3'(r);
      end else begin
        f3 = 3'($urandom);
      end
      r = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1 && f3[1:0] != 2'b11) r = r & ~((1 << f3[1:0]) - 1);
      addr  = 32'h80000000 + 32'(r);
      wdata = $urandom;
      model(addr, wen, f3, wdata, e_err, e_rd);
      run_txn(addr, wen, wdata, f3, $urandom_range(0, 3), n_strobe, strobe_at,
              s_addr, s_wdata, s_mask, s_ren, s_wen, resp_at, rdata, err, stable, busy_ok);
      chk($sformatf("rnd%0d err", i), {31'b0, err}, {31'b0, e_err});
      chk($sformatf("rnd%0d rdata", i), rdata, e_rd);
      chk($sformatf("rnd%0d resp_latency", i), resp_at, e_err ? 32'd1 : 32'(2 + lat));
      chk($sformatf("rnd%0d strobes", i), n_strobe, e_err ? 32'd0 : 32'd1);
      chk($sformatf("rnd%0d stable", i), {31'b0, stable}, 32'd1);
    end
    for (int w = 0; w < 16; w++)
      chk($sformatf("mem_image w%0d", w), mem_word[w],
          {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter LATENCY, default 1, extra wait cycles between memory access and response; legal range 0..15.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid input 1, req_ready output 1: request handshake from the execute stage.
REQ-006 SHALL have ports req_addr input XLEN, req_wen input 1 (1=store, 0=load), req_wdata input XLEN, req_func3 input 3 (RISC-V width/sign code).
REQ-007 SHALL have ports resp_valid output 1, resp_ready input 1: response handshake to writeback.
REQ-008 SHALL have ports resp_rdata output XLEN (extended load data), resp_err output 1 (misaligned or illegal access).
REQ-009 SHALL have memory-side ports mem_addr output XLEN, mem_wen output 1, mem_wmask output 8, mem_wdata output XLEN, mem_ren output 1, mem_rdata input XLEN; memory read is combinational, write commits once per asserted cycle.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-011 IDLE: req_ready=1; on req_valid&&req_ready, register addr, wen, wdata, func3 and go ACCESS, or RESP with err=1 if the request is illegal.
REQ-012 Illegal: load func3 in {011,110,111}; store func3 >= 011; halfword (func3[1:0]=01) with addr[0]=1; word (func3[1:0]=10) with addr[1:0]!=00.
REQ-013 Illegal requests SHALL never assert mem_ren or mem_wen; resp_rdata=0, resp_err=1.
REQ-014 ACCESS lasts exactly one cycle: mem_ren=!wen or mem_wen=wen, mem_addr={addr[XLEN-1:2],2'b00}.
REQ-015 Store lanes: sb mask 0x1<<addr[1:0]; sh mask 0x3<<addr[1:0]; sw mask 0xF; mem_wmask[7:4]=0; mem_wdata=wdata<<(8*addr[1:0]).
REQ-016 Load data SHALL be captured from mem_rdata at end of ACCESS: shifted right by 8*addr[1:0], then lb/lh sign-extended, lbu/lhu zero-extended, lw unchanged.
REQ-017 Store responses SHALL return resp_rdata=0, resp_err=0.
REQ-018 After ACCESS: if LATENCY=0 go RESP; else load counter with LATENCY and go WAIT.
REQ-019 WAIT: decrement counter each cycle; go RESP in the cycle the counter reaches 1.
REQ-020 Accept at edge N gives ACCESS in cycle N+1 and resp_valid first high in cycle N+2+LATENCY.
REQ-021 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready; on resp_valid&&resp_ready go IDLE.
REQ-022 req_ready SHALL be 0 in ACCESS, WAIT, RESP; at most one request outstanding; no same-cycle response-accept/request-accept overlap.
REQ-023 Outside ACCESS: mem_ren=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-024 req_* inputs SHALL be ignored when not in IDLE; captured values SHALL not change until return to IDLE.

Reset
REQ-025 While reset=1 at a rising edge: state<=IDLE, counter<=0, captured request and response registers<=0.
REQ-026 Reset outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0.
REQ-027 Reset in any state SHALL discard the in-flight access/response; no memory strobe in the cycle after reset edge.

Verification
REQ-028 LATENCY=1; lw addr 0x80000004, mem_rdata=0xDEADBEEF -> one-cycle mem_ren with mem_addr 0x80000004; resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, err=0.
REQ-029 lb addr 0x80000003, mem_rdata=0x80FF7F01 -> resp_rdata=0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x80000002 -> 0x000080FF.
REQ-030 sh addr 0x80000002, wdata 0x0000ABCD -> single cycle mem_wen=1, mem_wmask=0x0C, mem_wdata=0xABCD0000; resp_rdata=0.
REQ-031 sw addr 0x80000006 and lh addr 0x80000001 -> no mem strobes, resp_err=1 next cycle; func3=011 load -> resp_err=1.
REQ-032 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_ready=0, new req_valid ignored; assert reset during WAIT (LATENCY=4) -> IDLE next cycle, resp_valid never asserted.
